// File: rtl/game_pkg.sv
// Shared definitions for the dino VGA game: state codes, BCD digit type,
// screen geometry and a most-significant-digit-first BCD compare.
package game_pkg;

  localparam logic [1:0] GAME_INIT  = 2'd0;
  localparam logic [1:0] GAME_START = 2'd1;
  localparam logic [1:0] GAME_END   = 2'd2;
  localparam logic [1:0] GAME_RESET = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT  = GAME_INIT,
    ST_START = GAME_START,
    ST_END   = GAME_END,
    ST_RESET = GAME_RESET
  } game_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int WINDOW_WIDTH  = 640;
  localparam int WINDOW_HEIGHT = 480;

  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    logic       gt;
    logic       decided;
    bcd_digit_t da;
    bcd_digit_t db;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      da = a[i*4 +: 4];
      db = b[i*4 +: 4];
      if (!decided && (da != db)) begin
        gt      = (da > db);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter with synchronous clear, saturation at 9999
// and a combinational flag for the low-digit 99->00 rollover.
module bcd_counter4
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        rollover99
);

  logic [15:0] q_r;
  logic [15:0] next_s;
  logic        carry_s;
  logic        sat_s;

  // Ripple the +1 through the digits, each digit wrapping 9->0
  always_comb begin
    next_s  = q_r;
    carry_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry_s) begin
        if (q_r[i*4 +: 4] == 4'd9) begin
          next_s[i*4 +: 4] = 4'd0;
          carry_s          = 1'b1;
        end else begin
          next_s[i*4 +: 4] = q_r[i*4 +: 4] + 4'd1;
          carry_s          = 1'b0;
        end
      end else begin
        next_s[i*4 +: 4] = q_r[i*4 +: 4];
      end
    end
  end

  assign sat_s      = (q_r == 16'h9999);
  assign rollover99 = inc & ~sat_s & (q_r[7:0] == 8'h99);
  assign q          = q_r;

  // Score register: clear beats increment, 9999 holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 16'h0000;
    end else if (clr) begin
      q_r <= 16'h0000;
    end else if (inc && !sat_s) begin
      q_r <= next_s;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-state sequencer: INIT/START/END/RESET flow, score ticking and speed level.
// Optional best-score tracking is enabled with GAME_FLOW_HI_SCORE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_POINT = 8,
  parameter int LEVEL_MAX       = 7,
  parameter int RESET_HOLD      = 4
) (
  input  logic        game_clk,
  input  logic        rst,
  input  logic        key_jump,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic [15:0] score_bcd,
  output logic [2:0]  speed_level,
  output logic        clear_req
`ifdef GAME_FLOW_HI_SCORE_EN
  , output logic [15:0] hi_score_bcd
`endif
);

  localparam int TW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_POINT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [2:0]    LVL_MAX   = 3'(LEVEL_MAX);

  game_state_e   state_r;
  logic          key_prev_r;
  logic [TW-1:0] tick_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic          clear_req_r;
  logic [2:0]    speed_r;
  logic          key_rise_s;
  logic          score_clr_s;
  logic          score_inc_s;
  logic          rollover_s;
  logic [15:0]   score_s;

  // key_prev resets to 1 so a button held through reset is not an edge
  assign key_rise_s  = key_jump & ~key_prev_r;
  assign score_clr_s = (state_r == ST_END) & key_rise_s;
  assign score_inc_s = (state_r == ST_START) & ~collision & (tick_cnt_r == TICK_LAST);

  bcd_counter4 u_score (
    .clk       (game_clk),
    .rst       (rst),
    .clr       (score_clr_s),
    .inc       (score_inc_s),
    .q         (score_s),
    .rollover99(rollover_s)
  );

  // Flow FSM with its tick/hold counters, clear pulse and speed level
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      key_prev_r  <= 1'b1;
      tick_cnt_r  <= '0;
      hold_cnt_r  <= '0;
      clear_req_r <= 1'b0;
      speed_r     <= 3'd0;
    end else begin
      key_prev_r <= key_jump;
      case (state_r)
        ST_INIT: begin
          if (key_rise_s) begin
            state_r    <= ST_START;
            tick_cnt_r <= '0;
          end
        end
        ST_START: begin
          if (collision) begin
            state_r <= ST_END;
          end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
          end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
          end
        end
        ST_END: begin
          if (key_rise_s) begin
            state_r     <= ST_RESET;
            hold_cnt_r  <= '0;
            clear_req_r <= 1'b1;
          end
        end
        ST_RESET: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r     <= ST_START;
            tick_cnt_r  <= '0;
            clear_req_r <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        default: begin
          state_r     <= ST_INIT;
          clear_req_r <= 1'b0;
        end
      endcase
      // Level follows the same edge as the 99->00 score rollover
      if (score_clr_s) begin
        speed_r <= 3'd0;
      end else if (rollover_s && (speed_r < LVL_MAX)) begin
        speed_r <= speed_r + 3'd1;
      end else begin
        speed_r <= speed_r;
      end
    end
  end

  assign game_state  = state_r;
  assign score_bcd   = score_s;
  assign speed_level = speed_r;
  assign clear_req   = clear_req_r;

`ifdef GAME_FLOW_HI_SCORE_EN
  logic [15:0] hi_score_r;

  // Capture the final score at game over when it beats the record
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      hi_score_r <= 16'h0000;
    end else if ((state_r == ST_START) && collision && bcd_gt(score_s, hi_score_r)) begin
      hi_score_r <= score_s;
    end else begin
      hi_score_r <= hi_score_r;
    end
  end

  assign hi_score_bcd = hi_score_r;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: vector table, scoreboarded game runs,
// a fast-tick instance for saturation, and asynchronous reset mid-game.
module tb_game_flow_ctrl;

  logic        game_clk = 1'b0;
  logic        rst;
  logic        key_jump;
  logic        collision;
  logic [1:0]  game_state;
  logic [15:0] score_bcd;
  logic [2:0]  speed_level;
  logic        clear_req;
  logic        key2;
  logic        col2;
  logic [1:0]  st2;
  logic [15:0] sc2;
  logic [2:0]  sp2;
  logic        clr2;
`ifdef GAME_FLOW_HI_SCORE_EN
  logic [15:0] hi_score_bcd;
  logic [15:0] hi2;
  int          hi_model = 0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] sc;
    logic [2:0]  sp;
    logic        cl;
  } exp_t;

  typedef struct {
    logic        key;
    logic        col;
    logic [1:0]  st;
    logic [15:0] sc;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[12];

  always #5 game_clk = ~game_clk;

  game_flow_ctrl dut (
    .game_clk   (game_clk),
    .rst        (rst),
    .key_jump   (key_jump),
    .collision  (collision),
    .game_state (game_state),
    .score_bcd  (score_bcd),
    .speed_level(speed_level),
    .clear_req  (clear_req)
`ifdef GAME_FLOW_HI_SCORE_EN
    , .hi_score_bcd(hi_score_bcd)
`endif
  );

  game_flow_ctrl #(.TICKS_PER_POINT(2), .LEVEL_MAX(7), .RESET_HOLD(2)) dut_fast (
    .game_clk   (game_clk),
    .rst        (rst),
    .key_jump   (key2),
    .collision  (col2),
    .game_state (st2),
    .score_bcd  (sc2),
    .speed_level(sp2),
    .clear_req  (clr2)
`ifdef GAME_FLOW_HI_SCORE_EN
    , .hi_score_bcd(hi2)
`endif
  );

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [2:0] lvl(input int pts, input int lmax);
    return (pts / 100 > lmax) ? 3'(lmax) : 3'(pts / 100);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, "_state"}, 16'(game_state), 16'(e.st));
      chk({nm, "_score"}, score_bcd, e.sc);
      chk({nm, "_speed"}, 16'(speed_level), 16'(e.sp));
      chk({nm, "_clear"}, 16'(clear_req), 16'(e.cl));
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic apply(input logic k, input logic c, input string nm, input logic [1:0] st,
                       input logic [15:0] sc, input logic [2:0] sp, input logic cl);
    key_jump  = k;
    collision = c;
    exp_q.push_back('{st: st, sc: sc, sp: sp, cl: cl});
    name_q.push_back(nm);
    @(posedge game_clk);
    #1;
    check_out();
  endtask

  // Run a game from START entry to target points, then collide col_cyc cycles into the next window
  task automatic run_game(input int target, input int col_cyc);
    int n;
    int pts;
    n = target * 8 + col_cyc - 1;
    for (int k = 1; k <= n; k++) begin
      pts = k / 8;
      apply(((k % 5) == 0) && (k != n), 1'b0, "run", 2'd1, to_bcd(pts), lvl(pts, 7), 1'b0);
    end
    apply(1'b1, 1'b1, "collide", 2'd2, to_bcd(target), lvl(target, 7), 1'b0);
`ifdef GAME_FLOW_HI_SCORE_EN
    if (target > hi_model) hi_model = target;
    chk("hi_score", hi_score_bcd, to_bcd(hi_model));
`endif
    apply(1'b0, 1'b1, "end_hold", 2'd2, to_bcd(target), lvl(target, 7), 1'b0);
  endtask

  task automatic restart();
    apply(1'b1, 1'b0, "restart", 2'd3, 16'h0000, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, "reset_hold", 2'd3, 16'h0000, 3'd0, 1'b1);
    apply(1'b0, 1'b0, "reset_exit", 2'd1, 16'h0000, 3'd0, 1'b0);
  endtask

  initial begin
    int pts;
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 2'd0, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 16'h0000};

    rst = 1'b1; key_jump = 1'b1; collision = 1'b0; key2 = 1'b0; col2 = 1'b0;
    repeat (2) @(posedge game_clk);
    #1;
    chk("reset_state", 16'(game_state), 16'h0000);
    chk("reset_score", score_bcd, 16'h0000);
    chk("reset_speed", 16'(speed_level), 16'h0000);
    chk("reset_clear", 16'(clear_req), 16'h0000);
`ifdef GAME_FLOW_HI_SCORE_EN
    chk("reset_hi", hi_score_bcd, 16'h0000);
`endif
    rst = 1'b0;

    // Key held through reset, collision in INIT, then a real press
    for (int i = 0; i < 12; i++)
      apply(vecs[i].key, vecs[i].col, "vec", vecs[i].st, vecs[i].sc, 3'd0, 1'b0);

    run_game(41, 8);
    restart();
    run_game(120, 3);
    restart();
    run_game(80, 5);
    restart();
    run_game(300, 1);
    restart();
    for (int k = 1; k <= 20; k++) apply(1'b0, 1'b0, "g5", 2'd1, to_bcd(k / 8), 3'd0, 1'b0);

    // Fast instance: drive to 9999 and past, levels saturate at 7
    key2 = 1'b1;
    @(posedge game_clk);
    #1;
    chk("fast_start", 16'(st2), 16'h0001);
    key2 = 1'b0;
    for (int k = 1; k <= 20020; k++) begin
      @(posedge game_clk);
      #1;
      pts = (k / 2 > 9999) ? 9999 : k / 2;
      chk("fast_score", sc2, to_bcd(pts));
      chk("fast_speed", 16'(sp2), 16'(lvl(pts, 7)));
    end
    chk("fast_state", 16'(st2), 16'h0001);

    // Asynchronous reset in the middle of a cycle
    key_jump = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_state", 16'(game_state), 16'h0000);
    chk("midrst_score", score_bcd, 16'h0000);
    chk("midrst_speed", 16'(speed_level), 16'h0000);
    chk("midrst_clear", 16'(clear_req), 16'h0000);
    chk("midrst_fast_score", sc2, 16'h0000);
`ifdef GAME_FLOW_HI_SCORE_EN
    chk("midrst_hi", hi_score_bcd, 16'h0000);
`endif
    @(posedge game_clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, "post_rst", 2'd0, 16'h0000, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
